// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store unit between a pipeline and a byte-addressed data
//            memory. Aligned requests are passed through as one native memory
//            command. Misaligned loads are built from two word reads.
//            Misaligned stores are broken into consecutive byte stores.
//            Illegal size codes are answered with an error and no memory
//            access.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  unit idle, request can be accepted
//   req_store  in   1 = store, 0 = load
//   req_op     in   funct3 size code (B/H/W/BU/HU)
//   req_addr   in   byte address (ADDR_W)
//   req_wdata  in   store data, right-aligned
//   rsp_valid  out  one-cycle completion pulse
//   rsp_rdata  out  extended load result (0 for stores/errors)
//   rsp_err    out  illegal op, no memory access made
//   rsp_split  out  request was split into several accesses
//   mem_addr   out  memory byte address (ADDR_W)
//   mem_wdata  out  memory store data, right-aligned
//   mem_cmd    out  memory command (bit3 = read, 0000 = idle)
//   mem_rdata  in   memory read word, valid in the cycle mem_cmd is driven
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_split,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_cmd,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    LD_LO   = 3'd2,
    LD_HI   = 3'd3,
    ST_BYTE = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [3:0] CMD_IDLE = 4'b0000;
  localparam logic [3:0] CMD_LW   = 4'b1100;
  localparam logic [3:0] CMD_SB   = 4'b0101;

  state_t             state_q, state_d;
  logic               store_q, store_d;
  logic [2:0]         op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        lo_q, lo_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_split_q, rsp_split_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_cmd_q, mem_cmd_d;

  // Sign/zero extension of a right-aligned load value per size code.
  function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] v);
    logic [31:0] r;
    case (op[1:0])
      2'b00:   r = op[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'b01:   r = op[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Native memory command for a legal request.
  function automatic logic [3:0] native_cmd(input logic st, input logic [2:0] op);
    logic [3:0] c;
    if (st) begin
      case (op[1:0])
        2'b00:   c = 4'b0101;
        2'b01:   c = 4'b0110;
        default: c = 4'b0111;
      endcase
    end else begin
      case (op)
        3'b000:  c = 4'b1000;
        3'b100:  c = 4'b1001;
        3'b001:  c = 4'b1010;
        3'b101:  c = 4'b1011;
        default: c = 4'b1100;
      endcase
    end
    return c;
  endfunction

  logic        w_legal;
  logic        w_aligned;
  logic [55:0] w_raw;
  logic [31:0] w_sel;
  logic [31:0] w_load;
  logic [1:0]  w_next_cnt;
  logic [1:0]  w_last_cnt;
  logic [7:0]  w_next_byte;

  always_comb begin
    // Legality and alignment of the request on the input port.
    if (req_store) w_legal = (req_op == 3'b000) || (req_op == 3'b001) || (req_op == 3'b010);
    else           w_legal = (req_op != 3'b011) && (req_op != 3'b110) && (req_op != 3'b111);

    case (req_op[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~req_addr[0];
      default: w_aligned = (req_addr[1:0] == 2'b00);
    endcase

    // Load data window: in LD_HI the high word is live on mem_rdata and the
    // low word was captured in lo_q. Only the low 3 bytes of the high word
    // can ever fall inside a 4-byte window starting at offset 0..3.
    if (state_q == LD_HI) w_raw = {mem_rdata[23:0], lo_q};
    else                  w_raw = {24'h0, mem_rdata};

    case (addr_q[1:0])
      2'b00:   w_sel = w_raw[31:0];
      2'b01:   w_sel = w_raw[39:8];
      2'b10:   w_sel = w_raw[47:16];
      default: w_sel = w_raw[55:24];
    endcase
    w_load = extend(op_q, w_sel);

    // Byte-store sequencing.
    w_next_cnt = cnt_q + 2'd1;
    w_last_cnt = (op_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
    case (w_next_cnt)
      2'd1:    w_next_byte = wdata_q[15:8];
      2'd2:    w_next_byte = wdata_q[23:16];
      2'd3:    w_next_byte = wdata_q[31:24];
      default: w_next_byte = wdata_q[7:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_split_d = rsp_split_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_cmd_d   = CMD_IDLE;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (!w_legal) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_split_d = 1'b0;
            rsp_rdata_d = 32'h0;
          end else if (w_aligned) begin
            state_d     = ACCESS;
            mem_cmd_d   = native_cmd(req_store, req_op);
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
          end else if (!req_store) begin
            state_d    = LD_LO;
            mem_cmd_d  = CMD_LW;
            mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
          end else begin
            // First byte goes out straight from the request fields since
            // the registered copies are only loaded at this same edge.
            state_d     = ST_BYTE;
            cnt_d       = 2'd0;
            mem_cmd_d   = CMD_SB;
            mem_addr_d  = req_addr;
            mem_wdata_d = {24'h0, req_wdata[7:0]};
          end
        end
      end

      ACCESS: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_split_d = 1'b0;
        rsp_rdata_d = store_q ? 32'h0 : w_load;
      end

      LD_LO: begin
        state_d    = LD_HI;
        lo_d       = mem_rdata;
        mem_cmd_d  = CMD_LW;
        mem_addr_d = mem_addr_q + ADDR_W'(4);
      end

      LD_HI: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_split_d = 1'b1;
        rsp_rdata_d = w_load;
      end

      ST_BYTE: begin
        if (cnt_q == w_last_cnt) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_split_d = 1'b1;
          rsp_rdata_d = 32'h0;
        end else begin
          cnt_d       = w_next_cnt;
          mem_cmd_d   = CMD_SB;
          mem_addr_d  = addr_q + ADDR_W'(w_next_cnt);
          mem_wdata_d = {24'h0, w_next_byte};
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      op_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      lo_q        <= 32'h0;
      cnt_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      rsp_split_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_cmd_q   <= CMD_IDLE;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_split_q <= rsp_split_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_cmd_q   <= mem_cmd_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_split = rsp_split_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_cmd   = mem_cmd_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit with a 256-byte
//            behavioural data memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_split;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_cmd;
  logic [31:0] mem_rdata;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_split (rsp_split),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_cmd   (mem_cmd),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory: reads return the whole word containing mem_addr.
  logic [7:0] mem [256];
  logic [7:0] wbase;
  int         cmd_total = 0;

  assign wbase     = {mem_addr[7:2], 2'b00};
  assign mem_rdata = mem_cmd[3] ? {mem[wbase + 8'd3], mem[wbase + 8'd2],
                                   mem[wbase + 8'd1], mem[wbase]} : 32'h0;

  always @(posedge clk) begin
    if (mem_cmd != 4'b0000) cmd_total++;
    if (!mem_cmd[3] && mem_cmd != 4'b0000) begin
      mem[mem_addr[7:0]] = mem_wdata[7:0];
      if (mem_cmd[1:0] != 2'b01) mem[mem_addr[7:0] + 8'd1] = mem_wdata[15:8];
      if (mem_cmd[1:0] == 2'b11) begin
        mem[mem_addr[7:0] + 8'd2] = mem_wdata[23:16];
        mem[mem_addr[7:0] + 8'd3] = mem_wdata[31:24];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    logic        split;
    int          lat;
    int          ncmd;
  } vec_t;

  localparam int NV = 23;
  vec_t v [NV];

  task automatic run_req(input vec_t t, input int idx);
    int lat;
    int c0;
    @(negedge clk);
    chk($sformatf("v%0d ready_idle", idx), 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_store = t.st;
    req_op    = t.op;
    req_addr  = t.addr;
    req_wdata = t.wd;
    c0 = cmd_total;
    @(posedge clk);
    #1;
    // Scramble the request fields so unregistered use would show up.
    req_valid = 1'b0;
    req_store = ~t.st;
    req_op    = 3'b111;
    req_addr  = 32'hFFFF_FFF3;
    req_wdata = 32'h5A5A_5A5A;
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(t.lat));
    chk($sformatf("v%0d rdata", idx), rsp_rdata, t.rd);
    chk($sformatf("v%0d err", idx), 32'(rsp_err), 32'(t.err));
    chk($sformatf("v%0d split", idx), 32'(rsp_split), 32'(t.split));
    chk($sformatf("v%0d ready_in_resp", idx), 32'(req_ready), 32'h0);
    chk($sformatf("v%0d mem_cmds", idx), 32'(cmd_total - c0), 32'(t.ncmd));
    @(posedge clk);
    #1;
    req_store = 1'b0;
    req_op    = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    chk($sformatf("v%0d valid_pulse", idx), 32'(rsp_valid), 32'h0);
    chk($sformatf("v%0d rdata_hold", idx), rsp_rdata, t.rd);
  endtask

  initial begin
    int c0;
    int seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[3], mem[2], mem[1], mem[0]}         = 32'h4433_2211;
    {mem[7], mem[6], mem[5], mem[4]}         = 32'h8877_6655;
    {mem[19], mem[18], mem[17], mem[16]}     = 32'hDEAD_BEEF;

    //        st    op      addr          wdata         rdata         err   split lat ncmd
    v[0]  = '{1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 2, 1};
    v[1]  = '{1'b1, 3'b010, 32'h10,       32'h80FF0000, 32'h0,        1'b0, 1'b0, 2, 1};
    v[2]  = '{1'b0, 3'b000, 32'h13,       32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 2, 1};
    v[3]  = '{1'b0, 3'b100, 32'h13,       32'h0,        32'h00000080, 1'b0, 1'b0, 2, 1};
    v[4]  = '{1'b0, 3'b010, 32'h1,        32'h0,        32'h55443322, 1'b0, 1'b1, 3, 2};
    v[5]  = '{1'b0, 3'b001, 32'h12,       32'h0,        32'hFFFF80FF, 1'b0, 1'b0, 2, 1};
    v[6]  = '{1'b0, 3'b101, 32'h12,       32'h0,        32'h000080FF, 1'b0, 1'b0, 2, 1};
    v[7]  = '{1'b0, 3'b001, 32'h3,        32'h0,        32'h00005544, 1'b0, 1'b1, 3, 2};
    v[8]  = '{1'b0, 3'b101, 32'h7,        32'h0,        32'h00000088, 1'b0, 1'b1, 3, 2};
    v[9]  = '{1'b1, 3'b001, 32'h3,        32'h0000BEEF, 32'h0,        1'b0, 1'b1, 3, 2};
    v[10] = '{1'b0, 3'b010, 32'h4,        32'h0,        32'h887766BE, 1'b0, 1'b0, 2, 1};
    v[11] = '{1'b0, 3'b010, 32'h0,        32'h0,        32'hEF332211, 1'b0, 1'b0, 2, 1};
    v[12] = '{1'b0, 3'b010, 32'hFFFFFFFD, 32'h0,        32'h11000000, 1'b0, 1'b1, 3, 2};
    v[13] = '{1'b0, 3'b011, 32'h10,       32'h0,        32'h0,        1'b1, 1'b0, 1, 0};
    v[14] = '{1'b1, 3'b100, 32'h10,       32'h12345678, 32'h0,        1'b1, 1'b0, 1, 0};
    v[15] = '{1'b0, 3'b111, 32'h11,       32'h0,        32'h0,        1'b1, 1'b0, 1, 0};
    v[16] = '{1'b1, 3'b010, 32'h21,       32'hA1B2C3D4, 32'h0,        1'b0, 1'b1, 5, 4};
    v[17] = '{1'b0, 3'b010, 32'h21,       32'h0,        32'hA1B2C3D4, 1'b0, 1'b1, 3, 2};
    v[18] = '{1'b1, 3'b000, 32'h2E,       32'h123456AB, 32'h0,        1'b0, 1'b0, 2, 1};
    v[19] = '{1'b0, 3'b100, 32'h2E,       32'h0,        32'h000000AB, 1'b0, 1'b0, 2, 1};
    v[20] = '{1'b0, 3'b000, 32'h22,       32'h0,        32'hFFFFFFC3, 1'b0, 1'b0, 2, 1};
    v[21] = '{1'b1, 3'b001, 32'h12,       32'h00001234, 32'h0,        1'b0, 1'b0, 2, 1};
    v[22] = '{1'b0, 3'b101, 32'h12,       32'h0,        32'h00001234, 1'b0, 1'b0, 2, 1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_cmd", 32'(mem_cmd), 32'h0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready after reset", 32'(req_ready), 32'h1);

    for (int i = 0; i < NV; i++) run_req(v[i], i);

    // Memory contents left by the stores.
    chk("mem SH split byte3", 32'(mem[3]), 32'hEF);
    chk("mem SH split byte4", 32'(mem[4]), 32'hBE);
    chk("mem SB 0x2E", 32'(mem[46]), 32'hAB);
    chk("mem SW 0x24", 32'(mem[36]), 32'hA1);

    // Reset in the middle of a split word store at 0x5.
    @(negedge clk);
    req_valid = 1'b1;
    req_store = 1'b1;
    req_op    = 3'b010;
    req_addr  = 32'h5;
    req_wdata = 32'h1122_3344;
    c0 = cmd_total;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort cmd byte0", 32'(mem_cmd), 32'h5);
    chk("abort addr byte0", mem_addr, 32'h5);
    @(posedge clk);
    #1;
    chk("abort addr byte1", mem_addr, 32'h6);
    chk("abort wdata byte1", mem_wdata, 32'h33);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort mem_cmd async", 32'(mem_cmd), 32'h0);
    chk("abort rsp_split", 32'(rsp_split), 32'h0);
    chk("abort mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort ready after release", 32'(req_ready), 32'h1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    chk("abort no rsp_valid", 32'(seen), 32'h0);
    chk("abort bytes issued", 32'(cmd_total - c0), 32'h2);
    chk("abort mem 0x5", 32'(mem[5]), 32'h44);
    chk("abort mem 0x6", 32'(mem[6]), 32'h33);
    chk("abort mem 0x7", 32'(mem[7]), 32'h88);
    chk("abort mem 0x8", 32'(mem[8]), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
